// File: rtl/cdec_pkg.sv
// cdec_pkg: state, bus-source, write-enable, ALU and opcode-class encodings shared
// by the CDEC sequencer and datapath.
package cdec_pkg;
  typedef enum logic [3:0] {IDLE, F0, F1, F2, E0, E1, E2, E3, E4, HALTED} state_t;
  localparam logic [2:0] XSRC_PC  = 3'd0;
  localparam logic [2:0] XSRC_A   = 3'd1;
  localparam logic [2:0] XSRC_B   = 3'd2;
  localparam logic [2:0] XSRC_C   = 3'd3;
  localparam logic [2:0] XSRC_RD  = 3'd4;
  localparam logic [2:0] XSRC_R   = 3'd5;
  localparam logic [2:0] XSRC_FLG = 3'd6;
  localparam logic [2:0] XSRC_FF  = 3'd7;
  localparam logic [3:0] XDST_PC  = 4'd0;
  localparam logic [3:0] XDST_A   = 4'd1;
  localparam logic [3:0] XDST_B   = 4'd2;
  localparam logic [3:0] XDST_C   = 4'd3;
  localparam logic [3:0] XDST_MA  = 4'd4;
  localparam logic [3:0] XDST_WD  = 4'd5;
  localparam logic [3:0] XDST_I   = 4'd6;
  localparam logic [3:0] XDST_T   = 4'd7;
  localparam logic [3:0] XDST_R   = 4'd8;
  localparam logic [3:0] XDST_FLG = 4'd9;
  localparam logic [4:0] ALU_PASS = 5'd0;
  localparam logic [4:0] ALU_INC  = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_MOV  = 2'd1;
  localparam logic [1:0] CLS_JMP  = 2'd2;
  localparam logic [1:0] CLS_SYS  = 2'd3;
  localparam logic [1:0] SYS_LD   = 2'd0;
  localparam logic [1:0] SYS_ST   = 2'd1;
  localparam logic [1:0] SYS_NOP  = 2'd2;
  localparam logic [1:0] SYS_HALT = 2'd3;
endpackage

// File: rtl/cdec_seq_decode.sv
// cdec_seq_decode: control word and next-state hint from (state, I, SZCy).
// Register field codes 01/10/11 equal both the XSRC code and the XDST bit of A/B/C.
module cdec_seq_decode
  import cdec_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] I,
  input  logic [2:0] SZCy,
  output logic [2:0] xsrc,
  output logic [9:0] xdst,
  output logic [4:0] aluop,
  output logic       mem_we,
  output state_t     nxt
);
  logic [1:0] cls, fn, dd, ss;
  logic       imm, skip, taken;
  logic [2:0] k, b, body_src;
  assign cls = I[7:6];
  assign fn = I[5:4];
  assign dd = I[3:2];
  assign ss = I[1:0];
  assign imm = cls[1] ? 1'b1 : ss == 2'b00;
  assign skip = (cls != CLS_JMP && dd == 2'b00) || (cls == CLS_SYS && fn[1]);
  assign taken = fn == 2'b00 || (fn == 2'b01 && SZCy[1]) || (fn == 2'b10 && SZCy[0]) || (fn == 2'b11 && SZCy[2]);
  // k: index within E0..E4; b: step within the instruction body after the immediate prologue
  assign k = 3'(4'(state) - 4'(E0));
  assign b = imm ? k - 3'd2 : k;
  assign body_src = imm ? XSRC_RD : {1'b0, ss};
  always_comb begin
    xsrc = XSRC_PC;
    xdst = '0;
    aluop = ALU_PASS;
    mem_we = 1'b0;
    nxt = state;
    case (state)
      F0: begin
        xdst[XDST_MA] = 1'b1;
        xdst[XDST_R] = 1'b1;
        aluop = ALU_INC;
        nxt = F1;
      end
      F1: begin
        xsrc = XSRC_RD;
        xdst[XDST_I] = 1'b1;
        nxt = F2;
      end
      F2: begin
        xsrc = XSRC_R;
        xdst[XDST_PC] = 1'b1;
        nxt = (cls == CLS_SYS && fn == SYS_HALT) ? HALTED : skip ? F0 : E0;
      end
      E0, E1, E2, E3, E4: begin
        nxt = state_t'(4'(state) + 4'd1);
        if (imm && k == 3'd0) begin
          xdst[XDST_MA] = 1'b1;
          xdst[XDST_R] = 1'b1;
          aluop = ALU_INC;
        end else if (cls == CLS_JMP) begin
          xsrc = taken ? XSRC_RD : XSRC_R;
          xdst[XDST_PC] = 1'b1;
          nxt = F0;
        end else if (imm && k == 3'd1) begin
          xsrc = XSRC_R;
          xdst[XDST_PC] = 1'b1;
        end else if (cls == CLS_ALU) begin
          if (b == 3'd0) begin
            xsrc = body_src;
            xdst[XDST_T] = 1'b1;
          end else if (b == 3'd1) begin
            xsrc = {1'b0, dd};
            xdst[XDST_R] = 1'b1;
            xdst[XDST_FLG] = 1'b1;
            aluop = ALU_ADD + {3'b0, fn};
          end else begin
            xsrc = XSRC_R;
            xdst[{2'b0, dd}] = 1'b1;
            nxt = F0;
          end
        end else if (cls == CLS_MOV) begin
          xsrc = body_src;
          xdst[{2'b0, dd}] = 1'b1;
          nxt = F0;
        end else if (b == 3'd0) begin
          xsrc = XSRC_RD;
          xdst[XDST_MA] = 1'b1;
        end else if (b == 3'd1) begin
          xsrc = fn == SYS_ST ? {1'b0, dd} : XSRC_RD;
          xdst[fn == SYS_ST ? XDST_WD : {2'b0, dd}] = 1'b1;
          nxt = fn == SYS_ST ? nxt : F0;
        end else begin
          mem_we = 1'b1;
          nxt = F0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cdec_sequencer.sv
// cdec_sequencer: CDEC microsequencer top; state register plus start/halt control.
// Define CDEC_SEQ_STEP_EN to hold each instruction in F0 until a step pulse.
module cdec_sequencer
  import cdec_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] I,
  input  logic [2:0] SZCy,
  output logic [2:0] xsrc,
  output logic [9:0] xdst,
  output logic [4:0] aluop,
  output logic       mem_we,
  output logic       busy,
  output logic       halted
);
  state_t     state, nxt, dec_nxt;
  logic [2:0] dec_xsrc;
  logic [9:0] dec_xdst;
  logic [4:0] dec_aluop;
  logic       dec_we, hold;
  cdec_seq_decode u_dec (
    .state(state),
    .I(I),
    .SZCy(SZCy),
    .xsrc(dec_xsrc),
    .xdst(dec_xdst),
    .aluop(dec_aluop),
    .mem_we(dec_we),
    .nxt(dec_nxt)
  );
`ifdef CDEC_SEQ_STEP_EN
  assign hold = state == F0 && !step;
`else
  logic unused_step;
  assign unused_step = step;
  assign hold = 1'b0;
`endif
  assign nxt = state == IDLE ? (start ? F0 : IDLE) : hold ? state : dec_nxt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  assign xsrc = hold ? XSRC_PC : dec_xsrc;
  assign xdst = hold ? '0 : dec_xdst;
  assign aluop = hold ? ALU_PASS : dec_aluop;
  assign mem_we = hold ? 1'b0 : dec_we;
  assign busy = state != IDLE && state != HALTED;
  assign halted = state == HALTED;
endmodule
